// File: rtl/stream_mux_rr_if.sv
// Stream bundle between CHANNELS producers, the mux and one consumer.
// in_last/out_last exist only when STREAM_MUX_RR_LAST_EN is defined.
interface stream_mux_rr_if #(
   parameter int N        = 8,
   parameter int CHANNELS = 16
);
   localparam int SEL_W = $clog2(CHANNELS);

   logic [CHANNELS-1:0]   in_valid;
   logic [CHANNELS-1:0]   in_ready;
   logic [CHANNELS*N-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [N-1:0]          out_data;
   logic [SEL_W-1:0]      out_channel;
`ifdef STREAM_MUX_RR_LAST_EN
   logic [CHANNELS-1:0]   in_last;
   logic                  out_last;

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_channel, out_last
   );
   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_channel, out_last
   );
`else
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_channel
   );
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_channel
   );
`endif
endinterface

// File: rtl/stream_mux_rr.sv
// Registered CHANNELS:1 stream mux, round-robin or fixed-switch arbitration.
// Optional packet lock on in_last when STREAM_MUX_RR_LAST_EN is defined.
module stream_mux_rr #(
   parameter int N        = 8,
   parameter int CHANNELS = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        mode,
   input  logic [$clog2(CHANNELS)-1:0] switch,
   stream_mux_rr_if.slave              bus
);
   localparam int SEL_W = $clog2(CHANNELS);

   logic [SEL_W-1:0] last_grant;
   logic [SEL_W-1:0] grant;
   logic             granted;
   logic             load_ok;
   logic             xfer;
   logic [N-1:0]     sel_data;
   int               idx;
`ifdef STREAM_MUX_RR_LAST_EN
   logic             locked;
`endif

   assign load_ok = !bus.out_valid || bus.out_ready;
   assign xfer    = granted && load_ok;

   always_comb begin
      granted = 1'b0;
      grant   = '0;
      idx     = 0;
      if (mode) begin
         // An out-of-range switch never matches any channel, so it grants nothing.
         for (int i = 0; i < CHANNELS; i++) begin
            if (switch == SEL_W'(i) && bus.in_valid[SEL_W'(i)]) begin
               granted = 1'b1;
               grant   = SEL_W'(i);
            end
         end
      end else begin
         // Walk from farthest to nearest so the closest valid after last_grant wins.
         for (int k = CHANNELS; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % CHANNELS;
            if (bus.in_valid[SEL_W'(idx)]) begin
               granted = 1'b1;
               grant   = SEL_W'(idx);
            end
         end
      end
`ifdef STREAM_MUX_RR_LAST_EN
      if (locked) begin
         grant   = last_grant;
         granted = bus.in_valid[last_grant];
      end
`endif
   end

   assign sel_data = bus.in_data[int'(grant)*N +: N];

   // rst_n gates ready so the inputs see no acceptance while reset is held.
   always_comb begin
      bus.in_ready = '0;
      for (int i = 0; i < CHANNELS; i++)
         bus.in_ready[SEL_W'(i)] = rst_n && xfer && (grant == SEL_W'(i));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid   <= 1'b0;
         bus.out_data    <= '0;
         bus.out_channel <= '0;
         last_grant      <= SEL_W'(CHANNELS - 1);
`ifdef STREAM_MUX_RR_LAST_EN
         bus.out_last    <= 1'b0;
         locked          <= 1'b0;
`endif
      end else if (xfer) begin
         bus.out_valid   <= 1'b1;
         bus.out_data    <= sel_data;
         bus.out_channel <= grant;
         last_grant      <= grant;
`ifdef STREAM_MUX_RR_LAST_EN
         bus.out_last    <= bus.in_last[grant];
         locked          <= !bus.in_last[grant];
`endif
      end else if (bus.out_ready) begin
         bus.out_valid   <= 1'b0;
      end
   end
endmodule

// File: tb/tb_stream_mux_rr.sv
// Random + directed bench for stream_mux_rr against a queue-level arbitration model.
module tb_stream_mux_rr;
   localparam int N = 8;
   localparam int C = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       mode;
   logic [3:0] sw;
   logic       mode12;
   logic [3:0] sw12;
   int         passed = 0;
   int         total  = 0;
   int         grants[$];

   // model state: the beat held in the output register and arbitration history
   logic       m_valid;
   logic [7:0] m_data;
   int         m_ch;
   int         m_lastg;
   logic       m_locked;
   logic       m_last;

   always #5 clk = ~clk;

   stream_mux_rr_if #(.N(N), .CHANNELS(C))  bus ();
   stream_mux_rr_if #(.N(N), .CHANNELS(12)) bus12 ();

   stream_mux_rr #(.N(N), .CHANNELS(C)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .switch(sw), .bus(bus));
   stream_mux_rr #(.N(N), .CHANNELS(12)) dut12 (
      .clk(clk), .rst_n(rst_n), .mode(mode12), .switch(sw12), .bus(bus12));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc(2);
      rst_n = 1'b1;
   endtask

   // Which channel the rules say gets the next beat, -1 for none.
   function automatic int exp_grant();
`ifdef STREAM_MUX_RR_LAST_EN
      if (m_locked) return bus.in_valid[m_lastg] ? m_lastg : -1;
`endif
      if (mode) return (int'(sw) < C && bus.in_valid[sw]) ? int'(sw) : -1;
      for (int k = 1; k <= C; k++) begin
         if (bus.in_valid[(m_lastg + k) % C]) return (m_lastg + k) % C;
      end
      return -1;
   endfunction

   always @(negedge clk) begin
      int g;
      logic [C-1:0] er;
      if (!rst_n) begin
         m_valid = 1'b0; m_data = '0; m_ch = 0; m_lastg = C - 1;
         m_locked = 1'b0; m_last = 1'b0;
         chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
         chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
      end else begin
         chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
         chk("out_data", 64'(bus.out_data), 64'(m_data));
         chk("out_channel", 64'(bus.out_channel), 64'(m_ch));
`ifdef STREAM_MUX_RR_LAST_EN
         chk("out_last", 64'(bus.out_last), 64'(m_last));
`endif
         g  = exp_grant();
         er = '0;
         if (g >= 0 && (!m_valid || bus.out_ready)) er[g] = 1'b1;
         chk("in_ready", 64'(bus.in_ready), 64'(er));
         if (er != '0) begin
            grants.push_back(g);
            m_valid = 1'b1;
            m_data  = bus.in_data[g*N +: N];
            m_ch    = g;
            m_lastg = g;
`ifdef STREAM_MUX_RR_LAST_EN
            m_last   = bus.in_last[g];
            m_locked = !bus.in_last[g];
`endif
         end else if (bus.out_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   initial begin
      int exp_sp[7];
      exp_sp = '{3, 7, 12, 3, 7, 12, 3};
      rst_n = 1'b0; mode = 1'b0; sw = '0; mode12 = 1'b1; sw12 = 4'd13;
      bus.in_valid = '0; bus.out_ready = 1'b0;
      for (int i = 0; i < C; i++) bus.in_data[i*N +: N] = 8'hA0 + 8'(i);
      bus12.in_valid = '0; bus12.in_data = '0; bus12.out_ready = 1'b1;
`ifdef STREAM_MUX_RR_LAST_EN
      bus.in_last = '1; bus12.in_last = '1;
`endif
      cyc(3);
      rst_n = 1'b1;
      cyc(3);
      chk("idle_out_valid", 64'(bus.out_valid), 64'(0));

      // fairness: all valid, grants 0..15 then wrap
      grants.delete();
      bus.in_valid = '1; bus.out_ready = 1'b1;
      cyc(17);
      chk("fair_count", 64'(grants.size()), 64'(17));
      for (int i = 0; i < 17 && i < grants.size(); i++) chk("fair_seq", 64'(grants[i]), 64'(i % C));
      chk("fair_data", 64'(bus.out_data), 64'(8'hA0));

      // sparse round-robin with wrap 12 -> 3
      do_reset();
      grants.delete();
      bus.in_valid = 16'h1088;
      cyc(7);
      for (int i = 0; i < 7 && i < grants.size(); i++) chk("sparse_seq", 64'(grants[i]), 64'(exp_sp[i]));

      // fixed select
      grants.delete();
      mode = 1'b1; sw = 4'd5; bus.in_valid = '1;
      cyc(6);
      for (int i = 0; i < grants.size(); i++) chk("fixed_seq", 64'(grants[i]), 64'(5));
      bus.in_valid[5] = 1'b0;
      cyc(3);
      chk("fixed_drain_valid", 64'(bus.out_valid), 64'(0));
      chk("fixed_drain_ready", 64'(bus.in_ready), 64'(0));
      chk("fixed_nogrant", 64'(grants.size()), 64'(6));

      // round-robin resumes after last fixed grant
      grants.delete();
      mode = 1'b0; bus.in_valid = '1;
      cyc(2);
      chk("resume_0", 64'(grants[0]), 64'(6));
      chk("resume_1", 64'(grants[1]), 64'(7));

      // back-pressure with 3C held, then no-bubble reload of 3D
      bus.out_ready = 1'b0; bus.in_valid = 16'h0001;
      bus.in_data[0 +: 8] = 8'h3C; bus.in_data[8 +: 8] = 8'h3D;
      do_reset();
      cyc(1);
      bus.in_valid = 16'h0002;
      for (int i = 0; i < 4; i++) begin
         chk("bp_data", 64'(bus.out_data), 64'(8'h3C));
         chk("bp_ready", 64'(bus.in_ready), 64'(0));
         cyc(1);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 64'(bus.in_ready), 64'(16'h0002));
      cyc(1);
      chk("bp_reload_valid", 64'(bus.out_valid), 64'(1));
      chk("bp_reload_data", 64'(bus.out_data), 64'(8'h3D));

      // asynchronous reset with a beat held
      bus.out_ready = 1'b0;
      cyc(1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(bus.out_valid), 64'(0));
      chk("arst_data", 64'(bus.out_data), 64'(0));
      chk("arst_channel", 64'(bus.out_channel), 64'(0));
      chk("arst_ready", 64'(bus.in_ready), 64'(0));
      @(posedge clk);
      #1 rst_n = 1'b1;
      bus.in_valid = '0;
      cyc(3);
      chk("post_rst_idle", 64'(bus.out_valid), 64'(0));

`ifdef STREAM_MUX_RR_LAST_EN
      // 3-beat packet on channel 2 holds the grant over channel 4
      do_reset();
      grants.delete();
      bus.out_ready = 1'b1; bus.in_valid = 16'h0014; bus.in_last[2] = 1'b0;
      cyc(1);
      chk("pkt_b1", 64'({bus.out_channel, bus.out_last}), 64'({4'd2, 1'b0}));
      cyc(1);
      chk("pkt_b2", 64'({bus.out_channel, bus.out_last}), 64'({4'd2, 1'b0}));
      bus.in_last[2] = 1'b1;
      cyc(1);
      chk("pkt_b3", 64'({bus.out_channel, bus.out_last}), 64'({4'd2, 1'b1}));
      cyc(1);
      chk("pkt_next", 64'(bus.out_channel), 64'(4));
`endif

      // randomized traffic, mode and switch changes
      for (int c = 0; c < 3000; c++) begin
         bus.in_valid  = 16'($urandom) & 16'($urandom | $urandom);
         for (int i = 0; i < C; i++) bus.in_data[i*N +: N] = 8'($urandom);
         bus.out_ready = ($urandom_range(0, 3) != 0);
`ifdef STREAM_MUX_RR_LAST_EN
         bus.in_last   = 16'($urandom);
`endif
         if ($urandom_range(0, 19) == 0) mode = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 9) == 0) sw = 4'($urandom_range(0, 15));
         cyc(1);
      end

      // 12-channel instance: switch beyond range never grants
      bus.in_valid = '0;
      bus12.in_valid = '1;
      cyc(3);
      chk("oor_ready", 64'(bus12.in_ready), 64'(0));
      chk("oor_valid", 64'(bus12.out_valid), 64'(0));
      sw12 = 4'd11;
      #1;
      chk("c12_ready", 64'(bus12.in_ready), 64'(12'h800));
      cyc(1);
      chk("c12_channel", 64'(bus12.out_channel), 64'(11));
      chk("c12_valid", 64'(bus12.out_valid), 64'(1));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
